// File: rtl/a2o_wb_mem_node.sv
// rtl/a2o_wb_mem_node.sv - shared line memory behind the A2O direct-attach port and a Wishbone slave
module a2o_wb_mem_node #(
    parameter int          MEM_DW    = 128,
    parameter int          DEPTH_LG2 = 10,
    parameter int          WB_LAT    = 1,
    parameter logic [31:0] BASE      = 32'h0
) (
    input  logic                clk_1x,
    input  logic                rst_b,
    input  logic [0:31]         mem_adr,
    output logic [0:MEM_DW-1]   mem_dat,
    input  logic                mem_wr_val,
    input  logic [0:MEM_DW/8-1] mem_wr_be,
    input  logic [0:MEM_DW-1]   mem_wr_dat,
    input  logic                wb_cyc,
    input  logic                wb_stb,
    input  logic                wb_we,
    input  logic [31:0]         wb_adr,
    input  logic [3:0]          wb_sel,
    input  logic [31:0]         wb_datw,
    output logic                wb_ack,
    output logic                wb_err,
    output logic [31:0]         wb_datr,
    output logic [15:0]         wb_rd_cnt,
    output logic [15:0]         wb_wr_cnt
);
    localparam int          NB      = MEM_DW / 8;
    localparam int          OFF_LG2 = $clog2(NB);
    localparam int          NL      = MEM_DW / 32;
    localparam int          LANE_W  = (NL > 1) ? $clog2(NL) : 1;
    localparam logic [32:0] SPAN    = 33'd1 << (DEPTH_LG2 + OFF_LG2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, TURN} state_t;

    // Lines are held numerically: line byte 0 sits in the top 8 bits.
    logic [MEM_DW-1:0] line_mem [2**DEPTH_LG2];

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 we_q, we_d, rng_q, rng_d;
    logic [3:0]           sel_q, sel_d;
    logic [31:0]          datw_q, datw_d;
    logic [DEPTH_LG2-1:0] idx_q, idx_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic                 ack_q, ack_d, err_q, err_d;
    logic [31:0]          datr_q, datr_d;
    logic [15:0]          rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [MEM_DW-1:0]    mem_dat_q, mem_dat_d;

    logic [31:0]          req_off;
    logic                 req_rng;
    logic [DEPTH_LG2-1:0] mem_idx;
    logic [MEM_DW-1:0]    wb_line, dir_line, dir_wdat;
    logic                 wb_wr_fire;
    int                   lane_top;

    always_comb begin
        req_off    = wb_adr - BASE;
        req_rng    = (wb_adr >= BASE) && ({1'b0, req_off} < SPAN);
        mem_idx    = DEPTH_LG2'(mem_adr >> OFF_LG2);
        lane_top   = MEM_DW - 1 - 32 * int'(lane_q);
        wb_wr_fire = (state_q == RESP) && rng_q && we_q;
        mem_dat_d  = line_mem[mem_idx];

        wb_line = line_mem[idx_q];
        for (int k = 0; k < 4; k++) begin
            if (sel_q[3-k]) wb_line[lane_top-8*k -: 8] = datw_q[31-8*k -: 8];
        end

        // Same-line collision: start from the Wishbone-merged line so direct bytes land on top.
        dir_wdat = mem_wr_dat;
        dir_line = (wb_wr_fire && (idx_q == mem_idx)) ? wb_line : line_mem[mem_idx];
        for (int b = 0; b < NB; b++) begin
            if (mem_wr_be[b]) dir_line[MEM_DW-1-8*b -: 8] = dir_wdat[MEM_DW-1-8*b -: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        rng_d    = rng_q;
        sel_d    = sel_q;
        datw_d   = datw_q;
        idx_d    = idx_q;
        lane_d   = lane_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        datr_d   = 32'h0;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        case (state_q)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    we_d    = wb_we;
                    sel_d   = wb_sel;
                    datw_d  = wb_datw;
                    rng_d   = req_rng;
                    idx_d   = req_off[OFF_LG2 +: DEPTH_LG2];
                    lane_d  = LANE_W'((req_off >> 2) & 32'(NL - 1));
                    cnt_d   = 4'(WB_LAT - 1);
                    state_d = (WB_LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!wb_cyc)             state_d = IDLE;
                else if (cnt_q == 4'd1)  state_d = RESP;
                else                     cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                state_d = TURN;
                ack_d   = rng_q;
                err_d   = !rng_q;
                if (rng_q && !we_q) begin
                    datr_d = line_mem[idx_q][lane_top -: 32];
                    if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
                end
                if (wb_wr_fire && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_1x or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            rng_q     <= 1'b0;
            sel_q     <= 4'd0;
            datw_q    <= 32'h0;
            idx_q     <= '0;
            lane_q    <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            datr_q    <= 32'h0;
            rd_cnt_q  <= 16'h0;
            wr_cnt_q  <= 16'h0;
            mem_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            rng_q     <= rng_d;
            sel_q     <= sel_d;
            datw_q    <= datw_d;
            idx_q     <= idx_d;
            lane_q    <= lane_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            datr_q    <= datr_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            mem_dat_q <= mem_dat_d;
        end
    end

    always_ff @(posedge clk_1x) begin
        if (wb_wr_fire) line_mem[idx_q]   <= wb_line;
        if (mem_wr_val) line_mem[mem_idx] <= dir_line;
    end

    assign mem_dat   = mem_dat_q;
    assign wb_ack    = ack_q;
    assign wb_err    = err_q;
    assign wb_datr   = datr_q;
    assign wb_rd_cnt = rd_cnt_q;
    assign wb_wr_cnt = wr_cnt_q;
endmodule

// File: tb/tb_a2o_wb_mem_node.sv
// tb/tb_a2o_wb_mem_node.sv - directed plus random bench for a2o_wb_mem_node against a byte-array model
module tb_a2o_wb_mem_node;
    localparam logic [31:0] BASE1 = 32'h0000_4000;

    logic        clk_1x = 1'b0;
    logic        rst_b;
    logic [0:31]  mem_adr    [2];
    logic [0:127] mem_dat    [2];
    logic         mem_wr_val [2];
    logic [0:15]  mem_wr_be  [2];
    logic [0:127] mem_wr_dat [2];
    logic         wb_cyc [2], wb_stb [2], wb_we [2];
    logic [31:0]  wb_adr [2];
    logic [3:0]   wb_sel [2];
    logic [31:0]  wb_datw [2];
    logic         wb_ack [2], wb_err [2];
    logic [31:0]  wb_datr [2];
    logic [15:0]  wb_rd_cnt [2], wb_wr_cnt [2];

    logic [7:0] mm [2][256];
    int rd_m [2];
    int wr_m [2];
    int total = 0;
    int bad = 0;

    always #5 clk_1x = ~clk_1x;

    a2o_wb_mem_node #(.MEM_DW(128), .DEPTH_LG2(4), .WB_LAT(1), .BASE(32'h0)) u_lat1 (
        .clk_1x(clk_1x), .rst_b(rst_b), .mem_adr(mem_adr[0]), .mem_dat(mem_dat[0]),
        .mem_wr_val(mem_wr_val[0]), .mem_wr_be(mem_wr_be[0]), .mem_wr_dat(mem_wr_dat[0]),
        .wb_cyc(wb_cyc[0]), .wb_stb(wb_stb[0]), .wb_we(wb_we[0]), .wb_adr(wb_adr[0]),
        .wb_sel(wb_sel[0]), .wb_datw(wb_datw[0]), .wb_ack(wb_ack[0]), .wb_err(wb_err[0]),
        .wb_datr(wb_datr[0]), .wb_rd_cnt(wb_rd_cnt[0]), .wb_wr_cnt(wb_wr_cnt[0]));

    a2o_wb_mem_node #(.MEM_DW(128), .DEPTH_LG2(4), .WB_LAT(4), .BASE(BASE1)) u_lat4 (
        .clk_1x(clk_1x), .rst_b(rst_b), .mem_adr(mem_adr[1]), .mem_dat(mem_dat[1]),
        .mem_wr_val(mem_wr_val[1]), .mem_wr_be(mem_wr_be[1]), .mem_wr_dat(mem_wr_dat[1]),
        .wb_cyc(wb_cyc[1]), .wb_stb(wb_stb[1]), .wb_we(wb_we[1]), .wb_adr(wb_adr[1]),
        .wb_sel(wb_sel[1]), .wb_datw(wb_datw[1]), .wb_ack(wb_ack[1]), .wb_err(wb_err[1]),
        .wb_datr(wb_datr[1]), .wb_rd_cnt(wb_rd_cnt[1]), .wb_wr_cnt(wb_wr_cnt[1]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0 : BASE1;
    endfunction

    function automatic logic [0:127] mline(input int d, input int ln);
        logic [0:127] v;
        for (int j = 0; j < 16; j++) v[8*j +: 8] = mm[d][ln*16+j];
        return v;
    endfunction

    function automatic logic [31:0] mword(input int d, input int o);
        int o4;
        o4 = o & ~3;
        return {mm[d][o4], mm[d][o4+1], mm[d][o4+2], mm[d][o4+3]};
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dir_op(input int d, input logic [31:0] adr, input bit wr, input logic [0:15] be,
                          input logic [0:127] dat, input bit ck);
        int ln;
        logic [0:127] old;
        ln  = int'((adr >> 4) & 32'hF);
        old = mline(d, ln);
        @(negedge clk_1x);
        mem_adr[d] = adr; mem_wr_val[d] = wr; mem_wr_be[d] = be; mem_wr_dat[d] = dat;
        @(negedge clk_1x);
        mem_wr_val[d] = 1'b0;
        if (ck) chk("dir_rd_line", mem_dat[d], old);
        if (wr) for (int j = 0; j < 16; j++) if (be[j]) mm[d][ln*16+j] = dat[8*j +: 8];
    endtask

    task automatic wb_op(input int d, input bit we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dw, input int abort_k, input bit coll,
                         input logic [31:0] cadr, input logic [0:15] cbe, input logic [0:127] cdat,
                         output logic [31:0] rdat);
        int lat, off, nresp, cln;
        bit inr;
        lat   = lat_of(d);
        inr   = (adr >= base_of(d)) && ((adr - base_of(d)) < 32'd256);
        off   = int'((adr - base_of(d)) & 32'hFC);
        cln   = int'((cadr >> 4) & 32'hF);
        nresp = 0;
        rdat  = 32'h0;
        @(negedge clk_1x);
        wb_cyc[d] = 1'b1; wb_stb[d] = 1'b1; wb_we[d] = we;
        wb_adr[d] = adr; wb_sel[d] = sel; wb_datw[d] = dw;
        for (int k = 1; k <= lat + 8; k++) begin
            @(negedge clk_1x);
            if (wb_ack[d] || wb_err[d]) begin
                nresp++;
                if (nresp == 1) begin
                    rdat = wb_datr[d];
                    chk("wb_latency", k - 1, lat);
                    chk("wb_ack", wb_ack[d], inr);
                    chk("wb_err", wb_err[d], !inr);
                    if (!(inr && we)) chk("wb_datr", wb_datr[d], inr ? mword(d, off) : 32'h0);
                    wb_cyc[d] = 1'b0; wb_stb[d] = 1'b0;
                    if (inr && we)
                        for (int j = 0; j < 4; j++) if (sel[3-j]) mm[d][off+j] = dw[31-8*j -: 8];
                    if (coll)
                        for (int j = 0; j < 16; j++) if (cbe[j]) mm[d][cln*16+j] = cdat[8*j +: 8];
                    if (inr && we)  wr_m[d] = sat_inc(wr_m[d]);
                    if (inr && !we) rd_m[d] = sat_inc(rd_m[d]);
                    chk("wb_rd_cnt", wb_rd_cnt[d], rd_m[d]);
                    chk("wb_wr_cnt", wb_wr_cnt[d], wr_m[d]);
                end
            end
            if (coll && k == lat) begin
                mem_adr[d] = cadr; mem_wr_be[d] = cbe; mem_wr_dat[d] = cdat; mem_wr_val[d] = 1'b1;
            end
            if (coll && k == lat + 1) mem_wr_val[d] = 1'b0;
            if (abort_k != 0 && k == abort_k) begin
                wb_cyc[d] = 1'b0; wb_stb[d] = 1'b0;
            end
        end
        chk("wb_resp_count", nresp, (abort_k == 0) ? 1 : 0);
        wb_cyc[d] = 1'b0; wb_stb[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, op, seen;
        logic [31:0] a, r;
        logic [0:127] rl;
        rst_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_adr[i] = 0; mem_wr_val[i] = 0; mem_wr_be[i] = 0; mem_wr_dat[i] = 0;
            wb_cyc[i] = 0; wb_stb[i] = 0; wb_we[i] = 0; wb_adr[i] = 0; wb_sel[i] = 0; wb_datw[i] = 0;
            rd_m[i] = 0; wr_m[i] = 0;
        end
        repeat (2) @(negedge clk_1x);
        for (int i = 0; i < 2; i++) begin
            chk("rst_mem_dat", mem_dat[i], 0);
            chk("rst_ack", wb_ack[i], 0);
            chk("rst_err", wb_err[i], 0);
            chk("rst_datr", wb_datr[i], 0);
            chk("rst_rd_cnt", wb_rd_cnt[i], 0);
            chk("rst_wr_cnt", wb_wr_cnt[i], 0);
        end
        rst_b = 1'b1;

        for (int i = 0; i < 2; i++)
            for (int ln = 0; ln < 16; ln++)
                dir_op(i, 32'(ln * 16), 1'b1, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

        rl = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        dir_op(0, 32'h10, 1'b1, 16'hFFFF, rl, 1'b1);
        dir_op(0, 32'h10, 1'b0, 16'h0, 128'h0, 1'b1);
        chk("plan_line", mem_dat[0], rl);
        wb_op(0, 1'b0, 32'h18, 4'hF, 32'h0, 0, 1'b0, 0, 0, 0, r);
        chk("plan_rd_word", r, 32'h8899AABB);
        chk("plan_rd_cnt", wb_rd_cnt[0], 1);

        dir_op(1, 32'h10, 1'b1, 16'hFFFF, rl, 1'b1);
        wb_op(1, 1'b1, BASE1 + 32'h14, 4'b0011, 32'hDEADBEEF, 0, 1'b0, 0, 0, 0, r);
        dir_op(1, 32'h10, 1'b0, 16'h0, 128'h0, 1'b1);
        chk("plan_lane1", mem_dat[1][32:63], 32'h4455BEEF);
        chk("plan_wr_cnt", wb_wr_cnt[1], 1);

        wb_op(1, 1'b0, BASE1 + 32'd256, 4'hF, 32'h0, 0, 1'b0, 0, 0, 0, r);
        wb_op(1, 1'b1, BASE1 + 32'd256, 4'hF, 32'h0BAD0BAD, 0, 1'b0, 0, 0, 0, r);
        wb_op(1, 1'b0, BASE1 - 32'd4, 4'hF, 32'h0, 0, 1'b0, 0, 0, 0, r);
        wb_op(0, 1'b0, 32'd256, 4'hF, 32'h0, 0, 1'b0, 0, 0, 0, r);
        chk("oor_rd_cnt", wb_rd_cnt[1], 0);
        chk("oor_wr_cnt", wb_wr_cnt[1], 1);
        dir_op(1, 32'h0, 1'b0, 16'h0, 128'h0, 1'b1);
        wb_op(1, 1'b0, BASE1 + 32'd252, 4'hF, 32'h0, 0, 1'b0, 0, 0, 0, r);

        wb_op(1, 1'b1, BASE1 + 32'h30, 4'hF, 32'h12345678, 3, 1'b0, 0, 0, 0, r);
        chk("abort_wr_cnt", wb_wr_cnt[1], wr_m[1]);
        dir_op(1, 32'h30, 1'b0, 16'h0, 128'h0, 1'b1);
        wb_op(1, 1'b0, BASE1 + 32'h30, 4'hF, 32'h0, 0, 1'b0, 0, 0, 0, r);

        wb_op(0, 1'b1, 32'h20, 4'hF, 32'hAAAAAAAA, 0, 1'b1, 32'h20, 16'hC000,
              {16'h5555, 112'h0}, r);
        dir_op(0, 32'h20, 1'b0, 16'h0, 128'h0, 1'b1);
        chk("coll_word", mem_dat[0][0:31], 32'h5555AAAA);
        wb_op(1, 1'b1, BASE1 + 32'h44, 4'b1010, $urandom, 0, 1'b1, 32'h40, 16'h0FF0,
              {$urandom, $urandom, $urandom, $urandom}, r);
        dir_op(1, 32'h40, 1'b0, 16'h0, 128'h0, 1'b1);

        @(negedge clk_1x);
        wb_cyc[1] = 1'b1; wb_stb[1] = 1'b1; wb_we[1] = 1'b1;
        wb_adr[1] = BASE1 + 32'h50; wb_sel[1] = 4'hF; wb_datw[1] = 32'hCAFEF00D;
        repeat (2) @(negedge clk_1x);
        rst_b = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rstw_ack", wb_ack[i], 0);
            chk("rstw_rd_cnt", wb_rd_cnt[i], 0);
            chk("rstw_wr_cnt", wb_wr_cnt[i], 0);
            chk("rstw_mem_dat", mem_dat[i], 0);
            rd_m[i] = 0; wr_m[i] = 0;
        end
        @(negedge clk_1x);
        wb_cyc[1] = 1'b0; wb_stb[1] = 1'b0; rst_b = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk_1x);
            if (wb_ack[1] || wb_err[1]) seen++;
        end
        chk("rstw_no_resp", seen, 0);
        chk("rstw_wr_cnt_after", wb_wr_cnt[1], 0);
        dir_op(1, 32'h50, 1'b0, 16'h0, 128'h0, 1'b1);

        for (int i = 0; i < 80; i++) begin
            d  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            if (op == 0) begin
                dir_op(d, $urandom, 1'b1, 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
            end else if (op == 1) begin
                dir_op(d, $urandom, 1'b0, 16'h0, 128'h0, 1'b1);
            end else begin
                a = base_of(d) + $urandom_range(0, 299);
                if ($urandom_range(0, 7) == 0) a = base_of(d) - 32'd4;
                wb_op(d, 1'($urandom), a, 4'($urandom), $urandom, 0, ($urandom_range(0, 3) == 0),
                      32'($urandom_range(0, 255)), 16'($urandom),
                      {$urandom, $urandom, $urandom, $urandom}, r);
            end
        end
        for (int i = 0; i < 2; i++)
            for (int ln = 0; ln < 16; ln++)
                dir_op(i, 32'(ln * 16), 1'b0, 16'h0, 128'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
